kes_chien_dispatch: RTL

- Per-channel receiving end of the shared KES ELP interface.
- Sits between the shared KES block's per-channel ELP outputs and that channel's single Chien search engine.
- Advertises availability to the shared KES, latches one cluster (Multi chunks) of KES results, and dispatches each correctable errored chunk to Chien search in turn.
- Cross-checks the roots found against the KES error count, then reports per-chunk pass/fail status for the cluster.

---
 rtl/kes_chien_dispatch_pkg.sv | 21 ++
 rtl/kes_elp_cluster_latch.sv | 49 ++++
 rtl/kes_chien_dispatch.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/kes_chien_dispatch_pkg.sv
// Shared definitions for the per-channel KES-to-Chien dispatcher: FSM encoding
// and the LSB-first slice offsets used to pick one chunk out of a cluster vector.
package kes_chien_dispatch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        ISSUE,
        WAIT,
        DONE
    } dispatchState_t;

    function automatic int countOffset(input int chunk, input int countBits);
        return chunk * countBits;
    endfunction

    function automatic int elpOffset(input int chunk, input int symbolBits, input int coefficients);
        return chunk * symbolBits * coefficients;
    endfunction

endpackage

// File: rtl/kes_elp_cluster_latch.sv
// Holds one cluster of KES results and presents the count and ELP of the chunk
// currently selected by the dispatcher's index.
module kes_elp_cluster_latch
    import kes_chien_dispatch_pkg::*;
#(
    parameter int Multi             = 2,
    parameter int GaloisFieldDegree = 12,
    parameter int MaxErrorCountBits = 9,
    parameter int ELPCoefficients   = 15,
    parameter int ChunkIndexBits    = 1
) (
    input  logic                                                clock,
    input  logic                                                reset,
    input  logic                                                load,
    input  logic [Multi-1:0]                                    erroredIn,
    input  logic [Multi-1:0]                                    failIn,
    input  logic [Multi*MaxErrorCountBits-1:0]                  countIn,
    input  logic [Multi*GaloisFieldDegree*ELPCoefficients-1:0]  elpIn,
    input  logic [ChunkIndexBits-1:0]                           index,
    output logic [Multi-1:0]                                    latchedErrored,
    output logic [Multi-1:0]                                    latchedFail,
    output logic [Multi*MaxErrorCountBits-1:0]                  latchedCounts,
    output logic [MaxErrorCountBits-1:0]                        selCount,
    output logic [GaloisFieldDegree*ELPCoefficients-1:0]        selElp
);

    localparam int ElpBits = GaloisFieldDegree * ELPCoefficients;

    logic [Multi*ElpBits-1:0] latchedElp;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            latchedErrored <= '0;
            latchedFail    <= '0;
            latchedCounts  <= '0;
            latchedElp     <= '0;
        end else if (load) begin
            latchedErrored <= erroredIn;
            latchedFail    <= failIn;
            latchedCounts  <= countIn;
            latchedElp     <= elpIn;
        end
    end

    // The index only moves while the FSM is scanning, so these stay stable for a whole search.
    assign selCount = latchedCounts[countOffset(int'(index), MaxErrorCountBits) +: MaxErrorCountBits];
    assign selElp   = latchedElp[elpOffset(int'(index), GaloisFieldDegree, ELPCoefficients) +: ElpBits];

endmodule

// File: rtl/kes_chien_dispatch.sv
// Per-channel receiver of shared-KES ELP results: latches a cluster, feeds each
// correctable errored chunk to the Chien engine, and reports per-chunk status.
module kes_chien_dispatch
    import kes_chien_dispatch_pkg::*;
#(
    parameter int Multi             = 2,
    parameter int GaloisFieldDegree = 12,
    parameter int MaxErrorCountBits = 9,
    parameter int ELPCoefficients   = 15,
    parameter int ChunkIndexBits    = 1
) (
    input  logic                                                iClock,
    input  logic                                                iReset,
    input  logic                                                iIntraSharedKESEnd,
    input  logic [Multi-1:0]                                    iErroredChunk,
    input  logic [Multi-1:0]                                    iCorrectionFail,
    input  logic [Multi*MaxErrorCountBits-1:0]                  iClusterErrorCount,
    input  logic [Multi*GaloisFieldDegree*ELPCoefficients-1:0]  iELPCoefficients,
    output logic                                                oCSAvailable,
    input  logic                                                iCSReady,
    output logic                                                oCSStart,
    output logic [ChunkIndexBits-1:0]                           oCSChunkNumber,
    output logic [GaloisFieldDegree*ELPCoefficients-1:0]        oCSELPCoefficients,
    output logic [MaxErrorCountBits-1:0]                        oCSErrorCount,
    input  logic                                                iCSDone,
    input  logic [MaxErrorCountBits-1:0]                        iCSRootCount,
    output logic                                                oClusterDone,
    output logic [Multi-1:0]                                    oClusterCorrected,
    output logic [Multi-1:0]                                    oClusterFail,
    output logic [Multi*MaxErrorCountBits-1:0]                  oClusterErrorCount
);

    dispatchState_t                     state;
    logic [ChunkIndexBits-1:0]          index;
    logic [Multi-1:0]                   corrAcc, failAcc;
    logic [Multi-1:0]                   corrUpd, failUpd;
    logic [Multi-1:0]                   latchedErrored, latchedFail;
    logic [Multi*MaxErrorCountBits-1:0] latchedCounts;
    logic                               loadCluster;
    logic                               retire;
    logic                               lastChunk;

    assign loadCluster = (state == IDLE) && iIntraSharedKESEnd;
    assign lastChunk   = (index == ChunkIndexBits'(Multi - 1));

    kes_elp_cluster_latch #(
        .Multi             (Multi),
        .GaloisFieldDegree (GaloisFieldDegree),
        .MaxErrorCountBits (MaxErrorCountBits),
        .ELPCoefficients   (ELPCoefficients),
        .ChunkIndexBits    (ChunkIndexBits)
    ) clusterLatch (
        .clock          (iClock),
        .reset          (iReset),
        .load           (loadCluster),
        .erroredIn      (iErroredChunk),
        .failIn         (iCorrectionFail),
        .countIn        (iClusterErrorCount),
        .elpIn          (iELPCoefficients),
        .index          (index),
        .latchedErrored (latchedErrored),
        .latchedFail    (latchedFail),
        .latchedCounts  (latchedCounts),
        .selCount       (oCSErrorCount),
        .selElp         (oCSELPCoefficients)
    );

    assign oCSChunkNumber = index;
    assign oCSStart       = (state == ISSUE) && iCSReady;

    // Status update for the chunk under the index; retire means this chunk is finished.
    always_comb begin
        corrUpd = corrAcc;
        failUpd = failAcc;
        retire  = 1'b0;
        case (state)
            SCAN: begin
                if (!latchedErrored[index]) begin
                    corrUpd[index] = 1'b0;
                    failUpd[index] = 1'b0;
                    retire         = 1'b1;
                end else if (latchedFail[index]) begin
                    failUpd[index] = 1'b1;
                    retire         = 1'b1;
                end
            end
            WAIT: begin
                if (iCSDone) begin
                    retire = 1'b1;
                    if (iCSRootCount == oCSErrorCount) corrUpd[index] = 1'b1;
                    else                               failUpd[index] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state              <= IDLE;
            index              <= '0;
            corrAcc            <= '0;
            failAcc            <= '0;
            oCSAvailable       <= 1'b1;
            oClusterDone       <= 1'b0;
            oClusterCorrected  <= '0;
            oClusterFail       <= '0;
            oClusterErrorCount <= '0;
        end else begin
            oClusterDone <= 1'b0;
            corrAcc      <= corrUpd;
            failAcc      <= failUpd;
            case (state)
                IDLE: begin
                    if (iIntraSharedKESEnd) begin
                        state        <= SCAN;
                        index        <= '0;
                        corrAcc      <= '0;
                        failAcc      <= '0;
                        oCSAvailable <= 1'b0;
                    end
                end
                SCAN:  if (!retire) state <= ISSUE;
                ISSUE: if (iCSReady) state <= WAIT;
                DONE: begin
                    state        <= IDLE;
                    oCSAvailable <= 1'b1;
                end
                default: ;
            endcase
            // Results are registered on entry to DONE so they are valid during the DONE cycle.
            if (retire) begin
                if (lastChunk) begin
                    state              <= DONE;
                    oClusterDone       <= 1'b1;
                    oClusterCorrected  <= corrUpd;
                    oClusterFail       <= failUpd;
                    oClusterErrorCount <= latchedCounts;
                end else begin
                    state <= SCAN;
                    index <= index + ChunkIndexBits'(1);
                end
            end
        end
    end

endmodule
